// File: rtl/cursor_move_scheduler.sv
// ============================================================================
// Module   : cursor_move_scheduler
// Brief    : Push-button cursor stepper. Base tick, 2-FF sync + debounce,
//            auto-repeat FSM emitting one-cycle per-axis step strobes.
//            Optional FAST repeat stage enabled by macro CURSOR_TURBO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cursor_move_scheduler #(
  parameter int TICK_DIV       = 500000,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int REPEAT_DELAY   = 30,
  parameter int SLOW_PERIOD    = 4,
  parameter int FAST_PERIOD    = 1,
  parameter int FAST_AFTER     = 64
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_east,
  input  logic btn_west,
  input  logic btn_north,
  input  logic btn_south,
  output logic step_x,
  output logic dir_x,
  output logic step_y,
  output logic dir_y,
  output logic moving,
  output logic tick_out
);

  localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);

  localparam int c_DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [c_DW-1:0] c_DB_LAST = c_DW'(DEBOUNCE_TICKS - 1);

  localparam int c_PER_MAX0 = (REPEAT_DELAY > SLOW_PERIOD) ? REPEAT_DELAY : SLOW_PERIOD;
  localparam int c_PER_MAX  = (c_PER_MAX0 > FAST_PERIOD) ? c_PER_MAX0 : FAST_PERIOD;
  localparam int c_PW       = (c_PER_MAX > 1) ? $clog2(c_PER_MAX) : 1;
  localparam logic [c_PW-1:0] c_DELAY_LAST = c_PW'(REPEAT_DELAY - 1);
  localparam logic [c_PW-1:0] c_SLOW_LAST  = c_PW'(SLOW_PERIOD - 1);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_DELAY = 2'd1;
  localparam logic [1:0] c_S_SLOW  = 2'd2;

`ifdef CURSOR_TURBO_EN
  localparam logic [1:0] c_S_FAST  = 2'd3;
  localparam int c_SW = $clog2(FAST_AFTER + 1);
  localparam logic [c_SW-1:0] c_FAST_AFTER = c_SW'(FAST_AFTER);
  localparam logic [c_PW-1:0] c_FAST_LAST  = c_PW'(FAST_PERIOD - 1);
`endif

  // button bit order: 0 east, 1 west, 2 north, 3 south
  localparam int c_E = 0;
  localparam int c_W = 1;
  localparam int c_N = 2;
  localparam int c_S = 3;

  logic [c_TW-1:0] r_tick_cnt;
  logic            w_tick;
  logic [3:0]      w_btn_raw;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_deb;
  logic [3:0]      w_deb_nxt;
  logic [c_DW-1:0] r_dbc     [4];
  logic [c_DW-1:0] w_dbc_nxt [4];

  logic            w_x_act;
  logic            w_x_dir;
  logic            w_y_act;
  logic            w_y_dir;
  logic            w_active;
  logic [3:0]      w_pat;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_PW-1:0] r_per_cnt;
  logic [c_PW-1:0] w_per_nxt;
  logic [3:0]      r_pat;
  logic            w_issue;
  logic            r_step_x;
  logic            r_step_y;
  logic            r_dir_x;
  logic            r_dir_y;

`ifdef CURSOR_TURBO_EN
  logic [c_SW-1:0] r_stp_cnt;
  logic [c_SW-1:0] w_stp_nxt;
  logic [c_SW-1:0] w_stp_inc;
  assign w_stp_inc = (r_stp_cnt == c_FAST_AFTER) ? r_stp_cnt : r_stp_cnt + 1'b1;
`endif

  assign w_tick    = (r_tick_cnt == c_TICK_LAST);
  assign w_btn_raw = {btn_south, btn_north, btn_west, btn_east};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tick_cnt <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb      <= '0;
      for (int i = 0; i < 4; i++) r_dbc[i] <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_sync1    <= w_btn_raw;
      r_sync2    <= r_sync1;
      r_deb      <= w_deb_nxt;
      for (int i = 0; i < 4; i++) r_dbc[i] <= w_dbc_nxt[i];
    end
  end

  // The FSM sees the debounced value being committed on this very tick,
  // so the first step follows the qualifying tick by one cycle.
  always_comb begin
    w_deb_nxt = r_deb;
    for (int i = 0; i < 4; i++) begin
      w_dbc_nxt[i] = r_dbc[i];
      if (w_tick) begin
        if (r_sync2[i] == r_deb[i]) begin
          w_dbc_nxt[i] = '0;
        end else if (r_dbc[i] == c_DB_LAST) begin
          w_deb_nxt[i] = ~r_deb[i];
          w_dbc_nxt[i] = '0;
        end else begin
          w_dbc_nxt[i] = r_dbc[i] + 1'b1;
        end
      end
    end
  end

  assign w_x_act  = w_deb_nxt[c_E] ^ w_deb_nxt[c_W];
  assign w_x_dir  = w_deb_nxt[c_E] & ~w_deb_nxt[c_W];
  assign w_y_act  = w_deb_nxt[c_S] ^ w_deb_nxt[c_N];
  assign w_y_dir  = w_deb_nxt[c_S] & ~w_deb_nxt[c_N];
  assign w_active = w_x_act | w_y_act;
  assign w_pat    = {w_x_act, w_x_dir, w_y_act, w_y_dir};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= c_S_IDLE;
      r_per_cnt <= '0;
      r_pat     <= '0;
      r_step_x  <= 1'b0;
      r_step_y  <= 1'b0;
      r_dir_x   <= 1'b0;
      r_dir_y   <= 1'b0;
`ifdef CURSOR_TURBO_EN
      r_stp_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_per_cnt <= w_per_nxt;
      r_step_x  <= w_issue & w_x_act;
      r_step_y  <= w_issue & w_y_act;
`ifdef CURSOR_TURBO_EN
      r_stp_cnt <= w_stp_nxt;
`endif
      if (w_issue) begin
        r_pat <= w_pat;
        if (w_x_act) r_dir_x <= w_x_dir;
        if (w_y_act) r_dir_y <= w_y_dir;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = r_per_cnt;
    w_issue     = 1'b0;
`ifdef CURSOR_TURBO_EN
    w_stp_nxt   = r_stp_cnt;
`endif
    if (w_tick) begin
      if (r_state == c_S_IDLE) begin
        if (w_active) begin
          w_issue     = 1'b1;
          w_state_nxt = c_S_DELAY;
          w_per_nxt   = '0;
        end
      end else if (!w_active) begin
        w_state_nxt = c_S_IDLE;
        w_per_nxt   = '0;
      end else if (w_pat != r_pat) begin
        w_issue     = 1'b1;
        w_state_nxt = c_S_DELAY;
        w_per_nxt   = '0;
`ifdef CURSOR_TURBO_EN
        w_stp_nxt   = '0;
`endif
      end else begin
        case (r_state)
          c_S_DELAY: begin
            if (r_per_cnt == c_DELAY_LAST) begin
              w_issue     = 1'b1;
              w_state_nxt = c_S_SLOW;
              w_per_nxt   = '0;
`ifdef CURSOR_TURBO_EN
              w_stp_nxt   = '0;
`endif
            end else begin
              w_per_nxt = r_per_cnt + 1'b1;
            end
          end
          c_S_SLOW: begin
            if (r_per_cnt == c_SLOW_LAST) begin
              w_issue   = 1'b1;
              w_per_nxt = '0;
`ifdef CURSOR_TURBO_EN
              w_stp_nxt = w_stp_inc;
              if (w_stp_inc == c_FAST_AFTER) w_state_nxt = c_S_FAST;
`endif
            end else begin
              w_per_nxt = r_per_cnt + 1'b1;
            end
          end
`ifdef CURSOR_TURBO_EN
          c_S_FAST: begin
            if (r_per_cnt == c_FAST_LAST) begin
              w_issue   = 1'b1;
              w_per_nxt = '0;
            end else begin
              w_per_nxt = r_per_cnt + 1'b1;
            end
          end
`endif
          default: begin
            w_state_nxt = c_S_IDLE;
            w_per_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    moving = (r_state != c_S_IDLE);
  end

  assign step_x   = r_step_x;
  assign step_y   = r_step_y;
  assign dir_x    = r_dir_x;
  assign dir_y    = r_dir_y;
  assign tick_out = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_cursor_move_scheduler.sv
// ============================================================================
// Module   : tb_cursor_move_scheduler
// Brief    : Self-checking bench for cursor_move_scheduler with a cycle-level
//            behavioural model; follows CURSOR_TURBO_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cursor_move_scheduler;

  localparam int TD = 4;
  localparam int DB = 2;
  localparam int RD = 3;
  localparam int SP = 2;
  localparam int FP = 1;
  localparam int FA = 3;
`ifdef CURSOR_TURBO_EN
  localparam bit TURBO = 1'b1;
`else
  localparam bit TURBO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_e = 1'b0, btn_w = 1'b0, btn_n = 1'b0, btn_s = 1'b0;
  logic step_x, dir_x, step_y, dir_y, moving, tick_out;

  always #5 clk = ~clk;

  cursor_move_scheduler #(
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD),
    .SLOW_PERIOD(SP), .FAST_PERIOD(FP), .FAST_AFTER(FA)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .btn_east(btn_e), .btn_west(btn_w), .btn_north(btn_n), .btn_south(btn_s),
    .step_x(step_x), .dir_x(dir_x), .step_y(step_y), .dir_y(dir_y),
    .moving(moving), .tick_out(tick_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
  int m_dbc[4];
  int m_cyc = 0, m_n = 0, m_k = 0, m_lx = 0, m_ly = 0;
  logic e_sx = 0, e_sy = 0, e_dx = 0, e_dy = 0, e_mv = 0, e_tk = 0;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int i = 0; i < 4; i++) m_dbc[i] = 0;
    m_cyc = 0; m_n = 0; m_k = 0; m_lx = 0; m_ly = 0;
    e_sx = 0; e_sy = 0; e_dx = 0; e_dy = 0; e_mv = 0; e_tk = 0;
  endtask

  task automatic model_edge();
    logic [3:0] raw;
    int xv, yv, intv;
    bit fire;
    raw  = {btn_s, btn_n, btn_w, btn_e};
    e_sx = 0; e_sy = 0; fire = 0;
    if ((m_cyc % TD) == TD - 1) begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_dbc[i]++;
          if (m_dbc[i] == DB) begin m_deb[i] = ~m_deb[i]; m_dbc[i] = 0; end
        end else m_dbc[i] = 0;
      end
      xv = int'(m_deb[0]) - int'(m_deb[1]);
      yv = int'(m_deb[3]) - int'(m_deb[2]);
      if (xv == 0 && yv == 0) m_n = 0;
      else if (m_n == 0 || xv != m_lx || yv != m_ly) begin
        fire = 1; m_n = 1; m_k = 0;
      end else begin
        m_k++;
        intv = (m_n == 1) ? RD : ((TURBO && (m_n - 1 > FA)) ? FP : SP);
        if (m_k == intv) begin fire = 1; m_n++; m_k = 0; end
      end
      if (fire) begin
        e_sx = (xv != 0); e_sy = (yv != 0);
        if (xv != 0) e_dx = (xv > 0);
        if (yv != 0) e_dy = (yv > 0);
        m_lx = xv; m_ly = yv;
      end
    end
    m_s2 = m_s1; m_s1 = raw; m_cyc++;
    e_mv = (m_n > 0);
    e_tk = ((m_cyc % TD) == TD - 1);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset(); else model_edge();
  end

  // ---------------- per-cycle compare + event recorder ----------------
  int n_sx = 0, n_sy = 0, n_mv = 0, n_tk = 0, first_tk = -1;
  int sx_q[$];
  int sy_q[$];

  initial forever begin
    @(negedge clk);
    chk("cmp_tick_out", tick_out, e_tk);
    chk("cmp_step_x", step_x, e_sx);
    chk("cmp_step_y", step_y, e_sy);
    chk("cmp_dir_x", dir_x, e_dx);
    chk("cmp_dir_y", dir_y, e_dy);
    chk("cmp_moving", moving, e_mv);
    if (step_x) begin n_sx++; sx_q.push_back(m_cyc); end
    if (step_y) begin n_sy++; sy_q.push_back(m_cyc); end
    if (moving) n_mv++;
    if (tick_out) begin n_tk++; if (first_tk < 0) first_tk = m_cyc; end
  end

  task automatic clear_rec();
    n_sx = 0; n_sy = 0; n_mv = 0; n_tk = 0; first_tk = -1;
    sx_q.delete(); sy_q.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_s, btn_n, btn_w, btn_e} = b;
  endtask

  task automatic do_reset(input logic [3:0] held);
    @(negedge clk); #2;
    rst = 1'b1;
    set_btn(held);
    wait_cyc(3);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int exp2[$];
  int t;
  logic pre;

  initial begin
    for (int i = 0; i < 4; i++) m_dbc[i] = 0;
`ifdef CURSOR_TURBO_EN
    exp2 = '{8, 20, 28, 36, 44, 48, 52, 56};
`else
    exp2 = '{8, 20, 28, 36, 44, 52};
`endif

    // 1: idle after reset
    do_reset(4'b0000);
    clear_rec();
    wait_cyc(40);
    chk("t1_tick_count", n_tk, 10);
    chk("t1_first_tick", first_tk, 3);
    chk("t1_moving_cycles", n_mv, 0);
    chk("t1_steps", n_sx + n_sy, 0);

    // 2: hold east from reset release
    do_reset(4'b0001);
    clear_rec();
    wait_cyc(56);
    chk("t2_step_count", sx_q.size(), exp2.size());
    for (int i = 0; i < exp2.size(); i++)
      chk("t2_step_cycle", (i < sx_q.size()) ? sx_q[i] : -1, exp2[i]);
    chk("t2_step_y_count", n_sy, 0);
    chk("t2_dir_x", dir_x, 1);
    set_btn(4'b0000);
    wait_cyc(20);
    chk("t2_release_moving", moving, 0);

    // 3: short press spanning only one tick
    t = 0;
    while (!tick_out && t < 20) begin @(negedge clk); #1; t++; end
    chk("t3_tick_found", tick_out, 1);
    #1;
    clear_rec();
    set_btn(4'b0001);
    wait_cyc(5);
    set_btn(4'b0000);
    wait_cyc(20);
    chk("t3_steps", n_sx, 0);
    chk("t3_moving_cycles", n_mv, 0);

    // 4: east+west+north, then drop west
    do_reset(4'b0111);
    clear_rec();
    wait_cyc(30);
    chk("t4_step_x_count", n_sx, 0);
    chk("t4_step_y_count", n_sy, 3);
    chk("t4_dir_y", dir_y, 0);
    set_btn(4'b0101);
    wait_cyc(26);
    chk("t4_x_steps", sx_q.size(), 2);
    chk("t4_diag_cycle", (sx_q.size() > 0) ? sx_q[0] : -1, 40);
    chk("t4_delay_cycle", (sx_q.size() > 1) ? sx_q[1] : -1, 52);
    chk("t4_y_steps", sy_q.size(), 6);
    chk("t4_y_diag_cycle", (sy_q.size() > 4) ? sy_q[4] : -1, 40);
    chk("t4_dir_x", dir_x, 1);
    chk("t4_dir_y_final", dir_y, 0);

    // 5: release during DELAY, then re-press
    set_btn(4'b0000);
    wait_cyc(20);
    chk("t5_idle_moving", moving, 0);
    clear_rec();
    set_btn(4'b0001);
    t = 0;
    while (n_sx == 0 && t < 20) begin @(negedge clk); #1; t++; end
    chk("t5_first_step_seen", (n_sx > 0), 1);
    #1;
    set_btn(4'b0000);
    wait_cyc(30);
    chk("t5_steps_after_release", n_sx, 1);
    chk("t5_moving_after_release", moving, 0);
    clear_rec();
    set_btn(4'b0001);
    wait_cyc(14);
    chk("t5_repress_steps", n_sx, 1);
    chk("t5_repress_moving", moving, 1);

    // 6: async reset while stepping fast
    wait_cyc(50);
    t = 0;
    pre = 1'b0;
    while (!pre && t < 12) begin @(negedge clk); #1; pre = step_x; t++; end
    chk("t6_strobe_before_reset", pre, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_step_x", step_x, 0);
    chk("t6_rst_moving", moving, 0);
    chk("t6_rst_dir_x", dir_x, 0);
    chk("t6_rst_tick", tick_out, 0);
    wait_cyc(3);
    clear_rec();
    rst = 1'b0;
    wait_cyc(12);
    chk("t6_steps_after_reset", n_sx, 1);
    chk("t6_first_step_cycle", (sx_q.size() > 0) ? sx_q[0] : -1, 8);

    // randomized holds, occasional async reset
    for (int it = 0; it < 60; it++) begin
      set_btn(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) wait_cyc($urandom_range(100, 160));
      else wait_cyc($urandom_range(1, 60));
      if ($urandom_range(0, 15) == 0) begin
        #1 rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
      end
    end
    set_btn(4'b0000);
    wait_cyc(30);
    chk("final_idle_moving", moving, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
